pending_priority_encoder: RTL and testbench
===========================================

# pending_priority_encoder

Parametrised N-input priority encoder with request buffering and a valid/ready output. Request pulses are captured into a pending register. One index at a time is presented downstream, either with fixed MSB-highest priority or with round-robin priority. It generalises the combinational 8:3 priority encoder for use in front of interrupt/event consumers that may stall.

## Interface
- `N`, default 8: number of request lines; N >= 2.
- `W`, default $clog2(N): index width (derived; not overridden).
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_i`  in  N: request vector, sampled every edge; a 1 sets the pending bit.
- `mode_i`  in  1: 0 = fixed priority (bit N-1 highest), 1 = round-robin.
- `out_valid`  out  1: out_idx holds a selected request.
- `out_ready`  in  1: consumer accepts out_idx when out_valid & out_ready.
- `out_idx`  out  W: index of the selected request.
- `pending_o`  out  N: current pending register.
- `pend_cnt`  out  W+1: popcount of pending_o, registered alongside it.

## Operation
- **Pending update** each edge: `pending <= (pending & ~load_onehot) | req_i`. When a request arrives on the same edge as its bit is cleared, the request wins and the bit stays set as a new event.
- **Load condition:** `load = (!out_valid | out_ready) & (pending != 0)`. The selection is made from the registered pending value only; the same-cycle req_i does not take part.
- **On load:**
  - out_valid <= 1.
  - out_idx <= selected index.
  - That bit is cleared in pending.
  - The round-robin pointer `last` <= selected index.
- **When load is not possible:**
  - If out_valid & out_ready & pending == 0: out_valid <= 0.
  - If out_valid & !out_ready: out_valid and out_idx are held.
- **Fixed mode:** highest set index in pending.
- **Round-robin mode:**
  - Search downward starting at last-1, wrapping from 0 to N-1.
  - Within each pass, the first set bit wins.
  - With last = 0 after reset, the first round-robin search starts at N-1, which is identical to fixed mode.
- **Pointer and mode:**
  - `last` updates on every load in both modes.
  - A change of mode_i takes effect on the next load decision; no flush.
- **out_idx when out_valid = 0:** holds its last value and is don't-care for consumers.
- **pend_cnt:** always equals popcount(pending_o) in the same cycle. Maximum N; width W+1 covers it.

## Timing
- **Reset values** (asynchronous, while rst_n = 0):
  - pending_o = 0, pend_cnt = 0.
  - out_valid = 0, out_idx = 0.
  - last = 0.
  - Assertion mid-transaction discards the held index and all pending bits immediately.
- **Latency:** req_i high in cycle c gives pending set in cycle c+1, and out_valid/out_idx in cycle c+2, provided the output stage is free.
- **Throughput:** one index per cycle while out_ready = 1 and pending is non-zero.
- **Backpressure:** a held index is never re-selected; its bit was already cleared. New requests on other bits accumulate in pending. A request repeated on a bit that is still pending is merged, not counted twice.
- **Empty:** out_valid falls on the edge after the last accept if no pending bits remain.
- **Full:** pending = all ones is legal; there is no overflow indication.

## Structure
- **Package `prio_pkg`:** MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants, plus a `prio_clog2` helper function.
- **Sub-module `prio_find`** (parameter N): combinational highest-set-bit finder.
  - Inputs: vector. Outputs: found flag and index.
  - Instantiated twice for round-robin:
    - the masked vector (bits below last);
    - the unmasked vector (wrap pass).
  - The masked result is used if found; otherwise the unmasked result.
  - Fixed mode uses the unmasked instance.
- **Top level:** pending register, output register, pointer, popcount.

## Test plan
- **Reset:** hold rst_n = 0 with req_i = 8'hFF → out_valid = 0, out_idx = 0, pending_o = 0, pend_cnt = 0. Release with req_i = 0 → out_valid stays 0.
- **Fixed drain:** mode 0, out_ready = 1, one-cycle req_i = 8'b0010_0010 → two cycles later out_idx = 5 then 1 on consecutive cycles with out_valid high; out_valid = 0 on the third cycle.
- **Backpressure:**
  - out_ready = 0, pulse req_i = 8'h44 → out_idx = 6 held and pending_o = 8'h04, pend_cnt = 1.
  - Pulse req_i = 8'h40 while stalled → pending_o = 8'h44.
  - Raise out_ready → out_idx sequence 6, 6, 2.
- **Round-robin versus fixed** (N = 8, out_ready = 1, req_i held at 8'h91):
  - mode 1 → out_idx 7, 4, 0, 7, 4, 0.
  - mode 0 → 7, 7, 7 (starvation of bits 4 and 0).
- **Same-edge re-request:** pending_o = 8'h08 only, out_ready = 1, req_i = 8'h08 on the load edge → out_idx = 3 on two consecutive valid cycles, then out_valid = 0.
- **Reset mid-stream:** pending_o = 8'hFF with out_valid = 1, assert rst_n = 0 between edges → outputs clear asynchronously. After release with req_i = 0 → out_valid stays 0.

Source files
------------

// File: rtl/pending_priority_encoder_pkg.sv
// Shared constants and elaboration-time helpers for the pending priority encoder.
package prio_pkg;

    // Selection policy encoding carried on mode_i.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, never less than 1 so that N = 2 still yields a 1-bit index.
    function automatic int prio_clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage : prio_pkg

// File: rtl/prio_find.sv
// Combinational highest-set-bit finder: reports whether any bit of vec is set
// and, if so, the index of the most significant one.
module prio_find
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = prio_clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan upward so that the last set bit seen (the highest) overwrites earlier ones.
    always_comb begin
        found = 1'b0;
        idx   = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            found = found | vec[i];
            idx   = vec[i] ? W'(i) : idx;
        end
    end

endmodule : prio_find

// File: rtl/pending_priority_encoder.sv
// Buffered N-input priority encoder. Request pulses accumulate in a pending
// register; one index at a time is handed downstream over valid/ready, chosen
// either by fixed MSB-first priority or by a round-robin pointer.
module pending_priority_encoder
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = prio_clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         mode_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending_o,
    output logic [W:0]   pend_cnt
);

    // Number of set bits in a pending vector; N fits in W+1 bits.
    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] cnt;
        cnt = {(W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // State registers
    logic [N-1:0] pending_r;
    logic [W:0]   pend_cnt_r;
    logic         out_valid_r;
    logic [W-1:0] out_idx_r;
    logic [W-1:0] last_r;

    // Combinational decision signals
    logic [N-1:0] rr_mask_s;
    logic [N-1:0] masked_vec_s;
    logic         masked_found_s;
    logic [W-1:0] masked_idx_s;
    logic         full_found_s;
    logic [W-1:0] full_idx_s;
    logic [W-1:0] sel_idx_s;
    logic         load_s;
    logic [N-1:0] load_onehot_s;
    logic [N-1:0] pending_next_s;
    logic         out_valid_next_s;
    logic [W-1:0] out_idx_next_s;
    logic [W-1:0] last_next_s;

    // Round-robin window: only bits strictly below the last granted index.
    always_comb begin
        rr_mask_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            rr_mask_s[i] = (i < int'(last_r));
        end
    end

    assign masked_vec_s = pending_r & rr_mask_s;

    // First pass of the round-robin search (below the pointer).
    prio_find #(.N(N)) u_find_masked (
        .vec   (masked_vec_s),
        .found (masked_found_s),
        .idx   (masked_idx_s)
    );

    // Wrap pass for round-robin, and the whole search for fixed priority.
    prio_find #(.N(N)) u_find_full (
        .vec   (pending_r),
        .found (full_found_s),
        .idx   (full_idx_s)
    );

    // Pick the winning index according to the current mode.
    always_comb begin
        sel_idx_s = full_idx_s;
        case (mode_i)
            MODE_RR: begin
                if (masked_found_s) begin
                    sel_idx_s = masked_idx_s;
                end else begin
                    sel_idx_s = full_idx_s;
                end
            end
            MODE_FIXED: sel_idx_s = full_idx_s;
            default:    sel_idx_s = full_idx_s;
        endcase
    end

    // A new index is loaded when the output slot is free or being drained and
    // something is pending; the decision uses the registered pending value only.
    assign load_s = (~out_valid_r | out_ready) & full_found_s;

    // One-hot of the bit being handed out this cycle (all zero when not loading).
    always_comb begin
        load_onehot_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            load_onehot_s[i] = load_s & (sel_idx_s == W'(i));
        end
    end

    // New requests win over a same-edge clear so a re-request is not lost.
    assign pending_next_s = (pending_r & ~load_onehot_s) | req_i;

    // Output stage and pointer next-state.
    always_comb begin
        out_valid_next_s = out_valid_r;
        out_idx_next_s   = out_idx_r;
        last_next_s      = last_r;
        if (load_s) begin
            out_valid_next_s = 1'b1;
            out_idx_next_s   = sel_idx_s;
            last_next_s      = sel_idx_s;
        end else if (out_ready) begin
            // Slot accepted (or already empty) with nothing pending: go idle.
            out_valid_next_s = 1'b0;
        end else begin
            // Stalled: hold the presented index.
            out_valid_next_s = out_valid_r;
        end
    end

    // Pending register with its population count kept in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= {N{1'b0}};
            pend_cnt_r <= {(W+1){1'b0}};
        end else begin
            pending_r  <= pending_next_s;
            pend_cnt_r <= popcount(pending_next_s);
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= {W{1'b0}};
            last_r      <= {W{1'b0}};
        end else begin
            out_valid_r <= out_valid_next_s;
            out_idx_r   <= out_idx_next_s;
            last_r      <= last_next_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign pending_o = pending_r;
    assign pend_cnt  = pend_cnt_r;

endmodule : pending_priority_encoder

// File: tb/tb_pending_priority_encoder.sv
// Directed-vector bench for pending_priority_encoder (N = 8).
module tb_pending_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic       mode_i;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] pending_o;
    logic [3:0] pend_cnt;

    int n_vec;
    int n_err;

    pending_priority_encoder #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .mode_i    (mode_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pending_o (pending_o),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] idx);
        check_val({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check_val({tag, "_idx"}, 32'(out_idx), 32'(idx));
        end else begin
            check_val({tag, "_idx_dc"}, 32'(1'b0), 32'(out_valid));
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_i     = 8'hFF;
        mode_i    = 1'b0;
        out_ready = 1'b1;

        // ---------------- Reset held with all requests high ----------------
        repeat (3) tick();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_idx",   32'(out_idx),   32'd0);
        check_val("rst_pend",  32'(pending_o), 32'h00);
        check_val("rst_cnt",   32'(pend_cnt),  32'd0);
        req_i = 8'h00;
        #2;
        rst_n = 1'b1;
        tick();
        check_val("rel_valid", 32'(out_valid), 32'd0);
        check_val("rel_pend",  32'(pending_o), 32'h00);

        // ---------------- Fixed drain of 8'b0010_0010 ----------------
        req_i = 8'h22;
        tick();
        req_i = 8'h00;
        check_val("fd_pend", 32'(pending_o), 32'h22);
        check_val("fd_cnt",  32'(pend_cnt),  32'd2);
        check_val("fd_v0",   32'(out_valid), 32'd0);
        tick();
        check_out("fd_1", 1'b1, 3'd5);
        check_val("fd_pend1", 32'(pending_o), 32'h02);
        tick();
        check_out("fd_2", 1'b1, 3'd1);
        check_val("fd_pend2", 32'(pending_o), 32'h00);
        tick();
        check_out("fd_3", 1'b0, 3'd0);

        // ---------------- Backpressure ----------------
        out_ready = 1'b0;
        req_i     = 8'h44;
        tick();
        req_i = 8'h00;
        check_val("bp_pend0", 32'(pending_o), 32'h44);
        tick();
        check_out("bp_1", 1'b1, 3'd6);
        check_val("bp_pend1", 32'(pending_o), 32'h04);
        check_val("bp_cnt1",  32'(pend_cnt),  32'd1);
        tick();
        check_out("bp_hold", 1'b1, 3'd6);
        check_val("bp_pendh", 32'(pending_o), 32'h04);
        req_i = 8'h40;
        tick();
        req_i = 8'h00;
        check_out("bp_hold2", 1'b1, 3'd6);
        check_val("bp_pend2", 32'(pending_o), 32'h44);
        check_val("bp_cnt2",  32'(pend_cnt),  32'd2);
        out_ready = 1'b1;
        tick();
        check_out("bp_s2", 1'b1, 3'd6);
        check_val("bp_pend3", 32'(pending_o), 32'h04);
        tick();
        check_out("bp_s3", 1'b1, 3'd2);
        tick();
        check_out("bp_end", 1'b0, 3'd0);
        check_val("bp_cnt3", 32'(pend_cnt), 32'd0);

        // ---------------- Round-robin versus fixed, req held at 8'h91 ----------------
        do_reset();
        mode_i = 1'b1;
        req_i  = 8'h91;
        tick();
        check_val("rr_pend", 32'(pending_o), 32'h91);
        check_val("rr_cnt",  32'(pend_cnt),  32'd3);
        tick(); check_out("rr_1", 1'b1, 3'd7);
        tick(); check_out("rr_2", 1'b1, 3'd4);
        tick(); check_out("rr_3", 1'b1, 3'd0);
        tick(); check_out("rr_4", 1'b1, 3'd7);
        tick(); check_out("rr_5", 1'b1, 3'd4);
        tick(); check_out("rr_6", 1'b1, 3'd0);
        mode_i = 1'b0;
        tick(); check_out("fx_1", 1'b1, 3'd7);
        tick(); check_out("fx_2", 1'b1, 3'd7);
        tick(); check_out("fx_3", 1'b1, 3'd7);
        check_val("fx_pend", 32'(pending_o), 32'h91);
        req_i = 8'h00;
        repeat (5) tick();
        check_out("fx_drain", 1'b0, 3'd0);
        check_val("fx_pend0", 32'(pending_o), 32'h00);

        // ---------------- Same-edge re-request ----------------
        req_i = 8'h08;
        tick();
        check_val("se_pend", 32'(pending_o), 32'h08);
        check_out("se_0", 1'b0, 3'd0);
        tick();
        req_i = 8'h00;
        check_out("se_1", 1'b1, 3'd3);
        check_val("se_pend1", 32'(pending_o), 32'h08);
        tick();
        check_out("se_2", 1'b1, 3'd3);
        check_val("se_pend2", 32'(pending_o), 32'h00);
        tick();
        check_out("se_3", 1'b0, 3'd0);

        // ---------------- Reset mid-stream ----------------
        out_ready = 1'b0;
        req_i     = 8'hFF;
        tick();
        tick();
        req_i = 8'h00;
        check_out("ms_pre", 1'b1, 3'd7);
        check_val("ms_pend", 32'(pending_o), 32'hFF);
        check_val("ms_cnt",  32'(pend_cnt),  32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ms_valid", 32'(out_valid), 32'd0);
        check_val("ms_idx",   32'(out_idx),   32'd0);
        check_val("ms_pend0", 32'(pending_o), 32'h00);
        check_val("ms_cnt0",  32'(pend_cnt),  32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check_val("ms_rel_valid", 32'(out_valid), 32'd0);
        check_val("ms_rel_pend",  32'(pending_o), 32'h00);
        tick();
        check_val("ms_rel_valid2", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pending_priority_encoder
